// File: rtl/instr_mem_loader_if.sv
// Byte-stream and memory-write bundle for instr_mem_loader.
//   slave  modport : the loader (consumes the stream, drives the write port)
//   master modport : the stream source / observer (testbench, UART bridge)
// Signals:
//   i_VALID, i_DATA[7:0] : framed input byte stream
//   o_READY              : loader accepts a byte this cycle
//   o_WE, o_WA, o_WD     : byte-wide instruction memory write port
//   o_BUSY, o_DONE, o_ERR: frame status (busy, completion pulse, sticky abort)
interface instr_mem_loader_if #(
   parameter int AW = 16
);
   logic          i_VALID;
   logic [7:0]    i_DATA;
   logic          o_READY;
   logic          o_WE;
   logic [AW-1:0] o_WA;
   logic [7:0]    o_WD;
   logic          o_BUSY;
   logic          o_DONE;
   logic          o_ERR;

   modport slave (
      input  i_VALID, i_DATA,
      output o_READY, o_WE, o_WA, o_WD, o_BUSY, o_DONE, o_ERR
   );

   modport master (
      output i_VALID, i_DATA,
      input  o_READY, o_WE, o_WA, o_WD, o_BUSY, o_DONE, o_ERR
   );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: write-side companion of the byte-addressable instruction ROM.
// Accepts a framed byte stream (ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, payload) over
// valid/ready and issues one registered byte write per payload byte. o_BUSY holds
// the core off while a frame loads; a mid-frame idle of TIMEOUT cycles aborts.
// Ports:
//   i_CLK   : clock, rising edge
//   i_RST_N : asynchronous active-low reset
//   bus     : instr_mem_loader_if.slave (stream in, memory write port, status)
// Parameters: AW (address width), CW (count width), TIMEOUT (idle abort, >=2).
// Optional build macro INSTR_MEM_LOADER_CHECKSUM_EN: adds a trailing XOR checksum
// byte (state CHK); a mismatch aborts the frame with o_ERR.
module instr_mem_loader #(
   parameter int AW      = 16,
   parameter int CW      = 16,
   parameter int TIMEOUT = 1000000
) (
   input  logic              i_CLK,
   input  logic              i_RST_N,
   instr_mem_loader_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE
   } state_t;

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
   localparam state_t PAYLOAD_END = CHK;
`else
   localparam state_t PAYLOAD_END = DONE;
`endif

   state_t         state_q, state_d;
   logic           accept;
   logic           tmo_hit;
   logic           err_set;
   logic [TW-1:0]  tmo_q;
   logic [1:0]     idx_q;
   logic [7:0]     addr_lo_q;
   logic [7:0]     cnt_lo_q;
   logic [AW-1:0]  addr_q;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  hdr_cnt;
   logic           we_q;
   logic [AW-1:0]  wa_q;
   logic [7:0]     wd_q;
   logic           err_q;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
   logic [7:0]     csum_q;
`endif

   assign accept  = bus.i_VALID && bus.o_READY;
   // Abort fires on the TIMEOUT-th consecutive cycle without an accepted byte.
   assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1)) && !accept;
   assign hdr_cnt = CW'({bus.i_DATA, cnt_lo_q});

   assign bus.o_READY = (state_q != DONE);
   assign bus.o_BUSY  = (state_q != IDLE);
   assign bus.o_DONE  = (state_q == DONE);
   assign bus.o_WE    = we_q;
   assign bus.o_WA    = wa_q;
   assign bus.o_WD    = wd_q;
   assign bus.o_ERR   = err_q;

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      err_set = 1'b0;
      case (state_q)
         IDLE: if (accept) state_d = HDR;
         HDR: begin
            if (accept) begin
               if (idx_q == 2'd3) state_d = (hdr_cnt == '0) ? PAYLOAD_END : DATA;
            end else if (tmo_hit) begin
               state_d = IDLE;
               err_set = 1'b1;
            end
         end
         DATA: begin
            if (accept) begin
               if (cnt_q == CW'(1)) state_d = PAYLOAD_END;
            end else if (tmo_hit) begin
               state_d = IDLE;
               err_set = 1'b1;
            end
         end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
         CHK: begin
            if (accept) begin
               if (bus.i_DATA == csum_q) begin
                  state_d = DONE;
               end else begin
                  state_d = IDLE;
                  err_set = 1'b1;
               end
            end else if (tmo_hit) begin
               state_d = IDLE;
               err_set = 1'b1;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Idle counter only runs while a frame is open; any accepted byte restarts it.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N)                                     tmo_q <= '0;
      else if (state_q == IDLE || state_q == DONE || accept) tmo_q <= '0;
      else                                              tmo_q <= tmo_q + TW'(1);
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N)                         err_q <= 1'b0;
      else if (err_set)                     err_q <= 1'b1;
      else if (state_q == IDLE && accept)   err_q <= 1'b0;
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         idx_q     <= '0;
         addr_lo_q <= '0;
         cnt_lo_q  <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         wa_q      <= '0;
         wd_q      <= '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         if (accept) begin
            case (state_q)
               IDLE: begin
                  addr_lo_q <= bus.i_DATA;
                  idx_q     <= 2'd1;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                  csum_q    <= bus.i_DATA;
`endif
               end
               HDR: begin
                  idx_q <= idx_q + 2'd1;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ bus.i_DATA;
`endif
                  case (idx_q)
                     2'd1:    addr_q   <= AW'({bus.i_DATA, addr_lo_q});
                     2'd2:    cnt_lo_q <= bus.i_DATA;
                     default: cnt_q    <= hdr_cnt;
                  endcase
               end
               DATA: begin
                  we_q   <= 1'b1;
                  wa_q   <= addr_q;
                  wd_q   <= bus.i_DATA;
                  addr_q <= addr_q + AW'(1);
                  cnt_q  <= cnt_q - CW'(1);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ bus.i_DATA;
`endif
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: the driver builds frames from random or
// directed fields, derives the expected memory writes and frame outcomes from the
// frame arithmetic, and queues them; a negedge monitor pops and compares.
module tb_instr_mem_loader;
   localparam int AW      = 16;
   localparam int CW      = 16;
   localparam int TIMEOUT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   instr_mem_loader_if #(.AW(AW)) bus ();

   instr_mem_loader #(.AW(AW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
      .i_CLK   (clk),
      .i_RST_N (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct { logic [15:0] a; logic [7:0] d; int unsigned c; } wr_t;
   typedef struct { bit is_err; int unsigned c; } ev_t;

   wr_t        wq[$];
   ev_t        evq[$];
   logic [7:0] pl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   logic err_prev  = 1'b0;
   logic done_prev = 1'b0;
   wr_t  mw;
   ev_t  me;

   always @(negedge clk) begin
      if (!rst_n) begin
         err_prev  = 1'b0;
         done_prev = 1'b0;
      end else begin
         if (bus.o_WE) begin
            if (wq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", bus.o_WA, bus.o_WD);
            end else begin
               mw = wq.pop_front();
               chk("wr_addr", bus.o_WA, mw.a);
               chk("wr_data", bus.o_WD, mw.d);
               chk("wr_cycle", cyc, mw.c);
            end
         end
         if (bus.o_DONE) begin
            if (evq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got o_DONE at cycle %0d, none expected", cyc);
            end else begin
               me = evq.pop_front();
               chk("done_kind_err", {63'd0, me.is_err}, 64'd0);
               chk("done_cycle", cyc, me.c);
               chk("busy_in_done", bus.o_BUSY, 1);
            end
         end
         if (bus.o_ERR && !err_prev) begin
            if (evq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_err: got o_ERR rise at cycle %0d, none expected", cyc);
            end else begin
               me = evq.pop_front();
               chk("err_kind_err", {63'd0, me.is_err}, 64'd1);
               chk("err_cycle", cyc, me.c);
               chk("busy_after_err", bus.o_BUSY, 0);
            end
         end
         if (done_prev) begin
            chk("busy_after_done", bus.o_BUSY, 0);
            chk("done_one_cycle", bus.o_DONE, 0);
         end
         err_prev  = bus.o_ERR;
         done_prev = bus.o_DONE;
      end
   end

   // ---------------- driver ----------------
   task automatic send_byte(input logic [7:0] b, output int unsigned acc_cyc);
      int unsigned w;
      w = 0;
      @(negedge clk);
      while (!bus.o_READY && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus.o_READY) begin
         n_cmp++; n_bad++;
         $display("FAIL ready_wait: got o_READY=0 for %0d cycles, required 1", w);
      end
      bus.i_VALID = 1'b1;
      bus.i_DATA  = b;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
   endtask

   task automatic gap(input int n);
      if (n > 0) begin
         @(negedge clk);
         bus.i_VALID = 1'b0;
         repeat (n - 1) @(negedge clk);
      end
   endtask

   // Sends a frame with payload from pl; stop >= 0 goes silent after that many
   // payload bytes so the loader must time out.
   task automatic send_frame(input logic [15:0] addr, input int stop,
                             input bit bad_chk, input int max_gap);
      logic [7:0]  hb[4];
      logic [7:0]  x;
      int unsigned c;
      int          cnt;
      cnt   = pl.size();
      hb[0] = addr[7:0];
      hb[1] = addr[15:8];
      hb[2] = 8'(cnt);
      hb[3] = 8'(cnt >> 8);
      x     = 8'h00;
      for (int i = 0; i < 4; i++) begin
         send_byte(hb[i], c);
         x = x ^ hb[i];
         if (i == 0) begin
            chk("err_clear_on_start", bus.o_ERR, 0);
            chk("busy_after_first", bus.o_BUSY, 1);
         end
         if (i < 3 || cnt > 0) gap($urandom_range(0, max_gap));
      end
      for (int i = 0; i < cnt; i++) begin
         if (stop >= 0 && i >= stop) break;
         send_byte(pl[i], c);
         x = x ^ pl[i];
         wq.push_back('{16'(addr + 16'(i)), pl[i], c});
         if (i < cnt - 1) gap($urandom_range(0, max_gap));
      end
      if (stop >= 0) begin
         evq.push_back('{1'b1, c + TIMEOUT});
         gap(TIMEOUT + 3);
      end else begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
         gap($urandom_range(0, max_gap));
         send_byte(bad_chk ? (x ^ 8'h3C) : x, c);
         evq.push_back('{bad_chk, c});
`else
         if (bad_chk) x = ~x;
         evq.push_back('{1'b0, c});
`endif
         gap($urandom_range(0, 2) + 1);
      end
   endtask

   logic [15:0] r_addr;
   int          r_cnt;
   int          r_stop;
   int unsigned rc;
   logic [7:0]  rb;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i_VALID = 1'b0;
      bus.i_DATA  = 8'h00;
      #22;
      chk("rst_ready", bus.o_READY, 1);
      chk("rst_we",    bus.o_WE,    0);
      chk("rst_wa",    bus.o_WA,    0);
      chk("rst_wd",    bus.o_WD,    0);
      chk("rst_busy",  bus.o_BUSY,  0);
      chk("rst_done",  bus.o_DONE,  0);
      chk("rst_err",   bus.o_ERR,   0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed frames
      pl = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_frame(16'h1000, -1, 1'b0, 0);
      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(16'hFFFE, -1, 1'b0, 0);
      pl.delete();
      send_frame(16'h0000, -1, 1'b0, 0);
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(16'h2000, 2, 1'b0, 0);
      chk("err_sticky_after_timeout", bus.o_ERR, 1);
      pl = '{8'h5A};
      send_frame(16'h0000, -1, 1'b0, 0);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      pl = '{8'h5A};
      send_frame(16'h0000, -1, 1'b1, 0);
      chk("err_after_bad_chk", bus.o_ERR, 1);
`endif

      // Reset in the middle of a payload, while a write is on the port
      pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      send_byte(8'h00, rc);
      send_byte(8'h30, rc);
      send_byte(8'h04, rc);
      send_byte(8'h00, rc);
      send_byte(8'hA1, rc);
      wq.push_back('{16'h3000, 8'hA1, rc});
      send_byte(8'hA2, rc);
      wq.push_back('{16'h3001, 8'hA2, rc});
      chk("we_before_reset", bus.o_WE, 1);
      #1;
      rst_n       = 1'b0;
      bus.i_VALID = 1'b0;
      #1;
      chk("mid_rst_we",    bus.o_WE,    0);
      chk("mid_rst_busy",  bus.o_BUSY,  0);
      chk("mid_rst_ready", bus.o_READY, 1);
      chk("mid_rst_done",  bus.o_DONE,  0);
      while (wq.size() > 0 && wq[wq.size() - 1].c >= cyc) wq.pop_back();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_write_after_rst", bus.o_WE, 0);
      pl = '{8'hC0, 8'hC1, 8'hC2};
      send_frame(16'h3000, -1, 1'b0, 1);

      // Randomized frames
      for (int f = 0; f < 30; f++) begin
         r_cnt = $urandom_range(0, 8);
         if ($urandom_range(0, 2) == 0) r_addr = 16'hFFFF - 16'($urandom_range(0, 4));
         else                           r_addr = 16'($urandom);
         pl.delete();
         for (int i = 0; i < r_cnt; i++) begin
            rb = 8'($urandom);
            pl.push_back(rb);
         end
         r_stop = -1;
         if (r_cnt > 0 && $urandom_range(0, 7) == 0) r_stop = $urandom_range(0, r_cnt - 1);
         send_frame(r_addr, r_stop, ($urandom_range(0, 5) == 0), 3);
      end

      gap(5);
      chk("writes_drained", wq.size(), 0);
      chk("events_drained", evq.size(), 0);
      chk("idle_busy", bus.o_BUSY, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
